// File: rtl/svm_pkg.sv
// ----------------------------------------------------------------------------
// svm_pkg : shared sizes and FSM encoding for the SVM dot-product engine
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package svm_pkg;
  localparam int WIDTH    = 16;
  localparam int N_PIX    = 784;
  localparam int IMG_BASE = 784;
  localparam int ACC_W    = 42;
  localparam int FRAC     = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/svm_mult_acc.sv
// ----------------------------------------------------------------------------
// svm_mult_acc : operand register -> product register -> 42-bit accumulator
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module svm_mult_acc
  import svm_pkg::*;
#(
  parameter int WIDTH = svm_pkg::WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            en,
  input  logic signed [WIDTH-1:0]         a,
  input  logic signed [WIDTH-1:0]         b,
  output logic                            stage_busy,
  output logic signed [ACC_W-FRAC-1:0]    sum_hi
);

  logic signed [WIDTH-1:0]   a_r;
  logic signed [WIDTH-1:0]   b_r;
  logic                      d_v;
  logic                      p_v;
  logic signed [2*WIDTH-1:0] prod_r;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;

  always_comb begin
    acc_next = acc;
    if (p_v)
      acc_next = acc + {{(ACC_W-2*WIDTH){prod_r[2*WIDTH-1]}}, prod_r};
  end

  // Exposing the next value lets the result load in the same edge as the last add.
  assign sum_hi     = acc_next[ACC_W-1:FRAC];
  assign stage_busy = d_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r    <= '0;
      b_r    <= '0;
      d_v    <= 1'b0;
      p_v    <= 1'b0;
      prod_r <= '0;
      acc    <= '0;
    end else begin
      d_v <= en;
      if (en) begin
        a_r <= a;
        b_r <= b;
      end
      p_v <= d_v;
      if (d_v)
        prod_r <= a_r * b_r;
      if (clear)
        acc <= '0;
      else
        acc <= acc_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/svm_mac.sv
// ----------------------------------------------------------------------------
// svm_mac : streams one image and one support vector, returns their dot product
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module svm_mac
  import svm_pkg::*;
#(
  parameter int WIDTH    = svm_pkg::WIDTH,
  parameter int N_PIX    = svm_pkg::N_PIX,
  parameter int IMG_BASE = svm_pkg::IMG_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [15:0]       sv_base,
  output logic [10:0]       img_address,
  output logic              img_en,
  output logic              img_we,
  input  logic [WIDTH-1:0]  img_in_data,
  output logic [15:0]       sv_address,
  output logic              sv_en,
  input  logic [WIDTH-1:0]  sv_in_data,
  output logic [31:0]       result
);

  localparam int CW = $clog2(N_PIX);
  localparam int HW = ACC_W - FRAC;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    ret_v;
  logic                    clear;
  logic                    stage_busy;
  logic signed [HW-1:0]    sum_hi;

  assign img_we = 1'b0;

  svm_mult_acc #(
    .WIDTH (WIDTH)
  ) u_mult_acc (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .en         (ret_v),
    .a          (img_in_data),
    .b          (sv_in_data),
    .stage_busy (stage_busy),
    .sum_hi     (sum_hi)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ready       <= 1'b1;
      result      <= '0;
      img_en      <= 1'b0;
      sv_en       <= 1'b0;
      img_address <= '0;
      sv_address  <= '0;
      cnt         <= '0;
      ret_v       <= 1'b0;
      clear       <= 1'b0;
    end else begin
      ret_v <= img_en;
      clear <= 1'b0;
      case (state)
        // DONE is an idle cycle too, so a start there chains straight into a new run.
        IDLE, DONE: begin
          if (start) begin
            state       <= READ;
            ready       <= 1'b0;
            clear       <= 1'b1;
            img_en      <= 1'b1;
            sv_en       <= 1'b1;
            img_address <= 11'(IMG_BASE);
            sv_address  <= sv_base;
            cnt         <= '0;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (cnt == CW'(N_PIX - 1)) begin
            state  <= DRAIN;
            img_en <= 1'b0;
            sv_en  <= 1'b0;
          end else begin
            cnt         <= cnt + 1'b1;
            img_address <= img_address + 11'd1;
            sv_address  <= sv_address + 16'd1;
          end
        end
        DRAIN: begin
          if (!ret_v && !stage_busy) begin
            state  <= DONE;
            ready  <= 1'b1;
            result <= {{(32-HW){sum_hi[HW-1]}}, sum_hi};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_svm_mac.sv
// ----------------------------------------------------------------------------
// tb_svm_mac : scoreboard bench for svm_mac with behavioural BRAM models
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_svm_mac;

  localparam int NP   = 784;
  localparam int IB   = 784;
  localparam int LAT  = 788;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] sv_base = 16'd0;
  wire         ready;
  wire  [10:0] img_address;
  wire         img_en;
  wire         img_we;
  logic [15:0] img_in_data = 16'd0;
  wire  [15:0] sv_address;
  wire         sv_en;
  logic [15:0] sv_in_data = 16'd0;
  wire  [31:0] result;

  bit [15:0] img_mem [0:2047];
  bit [15:0] sv_mem  [0:65535];

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_last;
  logic        ready_q = 1'b1;

  svm_mac dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .sv_base     (sv_base),
    .img_address (img_address),
    .img_en      (img_en),
    .img_we      (img_we),
    .img_in_data (img_in_data),
    .sv_address  (sv_address),
    .sv_en       (sv_en),
    .sv_in_data  (sv_in_data),
    .result      (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (img_en) img_in_data <= img_mem[img_address];
    if (sv_en)  sv_in_data  <= sv_mem[sv_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] base);
    longint acc;
    longint sa;
    longint sb_v;
    acc = 0;
    for (int i = 0; i < NP; i++) begin
      sa   = $signed(img_mem[IB + i]);
      sb_v = $signed(sv_mem[16'(base + i)]);
      acc  = acc + sa * sb_v;
    end
    return 32'(acc >>> 14);
  endfunction

  // Scoreboard pop on every completion edge of ready.
  always @(negedge clk) begin
    if (reset && ready && !ready_q) begin
      check("sb_nonempty", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) check("result", result, sb.pop_front());
    end
    ready_q <= ready;
  end

  task automatic fill(input logic [15:0] iv, input logic [15:0] sv, input logic [15:0] base);
    for (int i = 0; i < NP; i++) begin
      img_mem[IB + i]       = iv;
      sv_mem[16'(base + i)] = sv;
    end
  endtask

  task automatic fill_rand(input logic [15:0] base, input int len);
    for (int i = 0; i < NP; i++) img_mem[IB + i] = 16'($urandom);
    for (int i = 0; i < len; i++) sv_mem[16'(base + i)] = 16'($urandom);
  endtask

  task automatic run_job(input logic [15:0] base, input bit hold, input int repulse_at,
                         input int abort_at);
    int          k;
    bit          aborted;
    logic [29:0] got_v;
    logic [29:0] exp_v;
    k = 0;
    aborted = 1'b0;
    while (!ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("idle_ready", ready, 1'b1);
    exp_last = model(base);
    sb.push_back(exp_last);
    sv_base = base;
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!hold) start = (k == repulse_at);
      if (k == repulse_at) sv_base = base ^ 16'h5A5A;
      if (k == abort_at) begin
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_out", {ready, result, img_en, sv_en, img_we, img_address, sv_address},
              {1'b1, 32'd0, 3'd0, 27'd0});
        sb.delete();
        aborted = 1'b1;
      end else begin
        if (k >= 1 && k <= NP) begin
          exp_v = {3'b110, 11'(IB + k - 1), 16'(base + k - 1)};
          got_v = {img_en, sv_en, img_we, img_address, sv_address};
        end else begin
          exp_v = 30'd0;
          got_v = {img_en, sv_en, img_we, 27'd0};
        end
        check("addr", got_v, exp_v);
      end
    end while (!ready && k < 1000 && !aborted);
    if (!aborted) check("latency", k, LAT);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_result", result, 32'd0);
    check("rst_en", {img_en, sv_en, img_we}, 3'd0);
    check("rst_addr", {img_address, sv_address}, 27'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {ready, img_en, sv_en}, 3'b100);

    fill(16'h4000, 16'h4000, 16'h0000);
    run_job(16'h0000, 1'b0, 0, 0);
    check("res_plus784", result, 32'h00C40000);

    fill(16'h4000, 16'hC000, 16'h1000);
    run_job(16'h1000, 1'b0, 0, 0);
    check("res_minus784", result, 32'hFF3C0000);

    fill(16'h2000, 16'h0000, 16'h2345);
    sv_mem[16'(16'h2345 + 783)] = 16'h4000;
    run_job(16'h2345, 1'b0, 0, 0);
    check("res_half", result, 32'h00002000);

    fill_rand(16'hFFF0, NP);
    run_job(16'hFFF0, 1'b0, 0, 0);

    fill_rand(16'h0040, NP);
    run_job(16'h0040, 1'b0, 0, 300);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job(16'h0040, 1'b0, 0, 0);

    fill_rand(16'h0400, NP);
    run_job(16'h0400, 1'b0, 100, 0);
    repeat (5) @(negedge clk);
    check("result_hold", result, exp_last);

    fill_rand(16'h0100, 2 * NP);
    run_job(16'h0100, 1'b1, 0, 0);
    run_job(16'h0200, 1'b0, 0, 0);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
